// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: width functions and accumulator state.
package adder_tree_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int sum_w(input int n, input int w);
        return w + clog2(n);
    endfunction

    function automatic int acc_w(input int n, input int w, input int g);
        return sum_w(n, w) + g;
    endfunction

    typedef enum logic {IDLE, ACCUM} acc_state_e;

endpackage

// File: rtl/adder_tree_stage.sv
// One registered pairwise-add level of the tree; holds data and valid while stalled.
module adder_tree_stage import adder_tree_pkg::*; #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [N-1:0][W-1:0]   in_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [N/2-1:0][W-1:0] out_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            out_valid <= in_valid;
            out_last  <= in_last;
            for (int p = 0; p < N/2; p++)
                out_data[p] <= in_data[2*p] + in_data[2*p+1];
        end
    end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree with a global stall; define PIPELINED_ADDER_TREE_ACC_EN
// to add a group accumulator stage driven by in_last.
module pipelined_adder_tree import adder_tree_pkg::*; #(
    parameter int N_IN      = 8,
    parameter int WIDTH     = 16,
    parameter int ACC_GUARD = 8,
    localparam int L        = clog2(N_IN),
    localparam int SUM_W    = sum_w(N_IN, WIDTH),
`ifdef PIPELINED_ADDER_TREE_ACC_EN
    localparam int OUT_W    = acc_w(N_IN, WIDTH, ACC_GUARD)
`else
    localparam int OUT_W    = SUM_W
`endif
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [0:N_IN-1][WIDTH-1:0]  in_data,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [OUT_W-1:0]            out_sum
);

    logic                        adv;
    logic [N_IN-1:0][SUM_W-1:0]  ext;
    logic                        tree_vld;
    logic                        tree_last;
    logic [SUM_W-1:0]            tree_sum;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Widen up front so every level can add at full width without overflow.
    always_comb begin
        ext = '0;
        for (int i = 0; i < N_IN; i++)
            ext[i] = SUM_W'($signed(in_data[i]));
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int NI = N_IN >> k;
        logic [NI-1:0][SUM_W-1:0]   din;
        logic                       din_vld;
        logic                       din_last;
        logic [NI/2-1:0][SUM_W-1:0] dout;
        logic                       dout_vld;
        logic                       dout_last;

        if (k == 0) begin : g_src
            assign din      = ext;
            assign din_vld  = in_valid;
            assign din_last = in_last;
        end else begin : g_chain
            assign din      = g_lvl[k-1].dout;
            assign din_vld  = g_lvl[k-1].dout_vld;
            assign din_last = g_lvl[k-1].dout_last;
        end

        adder_tree_stage #(.N(NI), .W(SUM_W)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .stall     (!adv),
            .in_valid  (din_vld),
            .in_last   (din_last),
            .in_data   (din),
            .out_valid (dout_vld),
            .out_last  (dout_last),
            .out_data  (dout)
        );
    end

    assign tree_vld  = g_lvl[L-1].dout_vld;
    assign tree_last = g_lvl[L-1].dout_last;
    assign tree_sum  = g_lvl[L-1].dout[0];

`ifdef PIPELINED_ADDER_TREE_ACC_EN
    acc_state_e       state;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] sum_x;

    assign sum_x = OUT_W'($signed(tree_sum));

    // Group accumulator: only the closing beat of a group produces a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (adv) begin
            out_valid <= 1'b0;
            if (tree_vld) begin
                case (state)
                    IDLE: begin
                        if (tree_last) begin
                            out_sum   <= sum_x;
                            out_valid <= 1'b1;
                        end else begin
                            acc   <= sum_x;
                            state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (tree_last) begin
                            out_sum   <= acc + sum_x;
                            out_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            acc <= acc + sum_x;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`else
    logic unused_last;

    assign unused_last = tree_last;
    assign out_valid   = tree_vld;
    assign out_sum     = tree_sum;
`endif

endmodule
